muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative RV32M/RV64M multiply/divide unit with valid/ready handshake.
- Sits beside the combinational ALU in the execute stage; the core stalls on in_ready/out_valid.
- Extends the ALU's operand-pair/op-select model to multi-cycle operations of width XLEN.
- Handles RISC-V divide-by-zero and signed-overflow corner cases in hardware.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- flush  input  1  synchronous abort of the in-flight operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  XLEN  operation result.
- busy  output  1  high in CALC, FIX, DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, busy=0, result=0, all datapath registers and counter cleared. Reset mid-operation discards the operation.
- Accept: in_valid && in_ready on a rising edge. a, b and op are latched that edge. Operand sign is captured per op:
  - signed: MULH a/b, MULHSU a, DIV/REM a/b.
  - unsigned: MUL (low word identical either way), MULHU, MULHSU b, DIVU, REMU.
- FSM: IDLE -> CALC, CALC -> FIX, FIX -> DONE, DONE -> IDLE.
  - IDLE: in_ready=1. On accept: divide op with b==0, or DIV/REM with a==1<<(XLEN-1) and b==all-ones -> DONE directly. Otherwise -> CALC with counter=XLEN, operands converted to magnitudes.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - Counter decrements each cycle; -> FIX when the counter reaches 1 on this edge, i.e. exactly XLEN CALC cycles.
  - FIX: apply result sign.
    - Product negated if operand signs differ.
    - Quotient negated if signs differ.
    - Remainder takes the dividend's sign.
    - Select low word (MUL), high word (MULH*), quotient or remainder. Register into result; -> DONE.
  - DONE: out_valid=1; result held stable. -> IDLE on the edge where out_ready=1.
- Latency: accept edge to out_valid high = XLEN+2 edges for normal ops (33+1 at XLEN=32). Special cases take 1 edge.
- Special results:
  - div-by-zero: DIV/DIVU quotient = all-ones; REM/REMU = a.
  - overflow: DIV = 1<<(XLEN-1); REM = 0.
- Backpressure: while out_valid && !out_ready, result and out_valid are held and in_valid is ignored (in_ready=0). No overlap of operations.
- flush: in CALC or FIX -> IDLE next edge, no out_valid, result unchanged. In DONE -> IDLE, dropping the result. In IDLE, flush has priority over in_valid (no accept).
- Result is unaffected by changes on a, b or op after the accept edge.

Optional Feature:
- FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*XLEN product and go IDLE -> DONE on the accept edge (1-edge latency).
  - Divide path unchanged.
- FAST_MUL_EN undefined: multiplies use the iterative path with XLEN+2 latency. No combinational multiplier is synthesised.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), out_ready=1 -> result 0xFFFFFFEB; out_valid first high 34 edges after accept (1 with FAST_MUL_EN).
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/3 -> 0x55555554; REMU -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Each gives out_valid one edge after accept.
- DONE with out_ready=0 for 5 cycles while in_valid=1 -> result/out_valid stable, in_ready=0, no second accept. out_ready=1 -> IDLE next edge.
- flush on the 10th CALC cycle -> IDLE next edge, out_valid never rises; following DIVU 100/7 -> 14.
- rst_n pulsed low mid-CALC -> immediate IDLE, outputs 0; following REMU 100/7 -> 2.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M mul/div: XLEN+2 edges from accept to out_valid, 1 edge for div corner cases.
// Holds its result while out_ready is low and refuses new requests. FAST_MUL_EN: single-edge multiplies.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic            div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign is_div      = op[2];
    assign a_sgn       = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    assign b_sgn       = is_div ? ~op[0] : (op[1:0] == 2'b01);
    assign a_neg       = a_sgn & a[XLEN-1];
    assign b_neg       = b_sgn & b[XLEN-1];
    assign a_mag       = a_neg ? -a : a;
    assign b_mag       = b_neg ? -b : b;
    assign div_zero    = is_div && (b == '0);
    assign div_ovf     = is_div && !op[0] && (a == MIN_NEG) && (b == '1);
    assign special     = div_zero || div_ovf;
    assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_NEG);
    assign accept      = in_valid && (state_q == S_IDLE) && !flush;

    // Multiply: acc = {partial sum, remaining multiplier bits}. Divide: acc = {remainder, quotient/dividend}.
    logic [XLEN:0]     mul_sum, div_trial;
    logic [XLEN-1:0]   div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = (div_trial >= {1'b0, opb_q});
    assign div_sub   = div_trial[XLEN-1:0] - opb_q;
    assign div_next  = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                              : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    assign prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo_s  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_s  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = '0;
        if (op_q[2])                fix_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
        else                        fix_res = prod_s[2*XLEN-1:XLEN];
    end

`ifdef FAST_MUL_EN
    // Sign-extending to 2*XLEN lets one unsigned multiplier cover all four multiply flavours.
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_res;
    assign fast_a    = {{XLEN{a_neg}}, a};
    assign fast_b    = {{XLEN{b_neg}}, b};
    assign fast_prod = fast_a * fast_b;
    assign fast_res  = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = op;
                    sa_d = a_neg;
                    sb_d = b_neg;
                    if (special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end
`ifdef FAST_MUL_EN
                    else if (!is_div) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(XLEN);
                        acc_d   = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                        opb_d   = is_div ? b_mag : a_mag;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
            end
            default: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus randomized operations against an arithmetic model.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b, result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat_exp;
        logic        has_lit;
        logic [31:0] lit;
    } exp_t;

    exp_t        q[$];
    int          lat = 0;
    logic [31:0] last_res = 32'h0;
    logic        cur_has_lit = 1'b0;
    logic [31:0] cur_lit = 32'h0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, sp;
        logic [63:0] ux, uy, p;
        logic        ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'h0, x};
        uy  = {32'h0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin sp = sx * sy; p = sp; return p[63:32]; end
            3'd2: begin sp = sx * longint'(uy); p = sp; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sp = sx / sy; p = sp; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                sp = sx % sy; p = sp; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
`ifdef FAST_MUL_EN
        if (!o[2]) return 1;
`endif
        return XLEN + 2;
    endfunction

    // Single compare process: the model's view of the handshake decides what every output must be.
    always @(negedge clk) begin
        logic        ov_exp;
        logic [31:0] res_exp;
        if (!rst_n) begin
            chk("reset in_ready", {31'h0, in_ready}, 32'h1);
            chk("reset busy", {31'h0, busy}, 32'h0);
            chk("reset out_valid", {31'h0, out_valid}, 32'h0);
            chk("reset result", result, 32'h0);
            q.delete();
            last_res = 32'h0;
        end else begin
            lat++;
            ov_exp  = (q.size() != 0) && (lat >= q[0].lat_exp);
            res_exp = ov_exp ? q[0].res : last_res;
            chk("in_ready", {31'h0, in_ready}, {31'h0, q.size() == 0});
            chk("busy", {31'h0, busy}, {31'h0, q.size() != 0});
            chk("out_valid", {31'h0, out_valid}, {31'h0, ov_exp});
            chk("result", result, res_exp);
            if (ov_exp && lat == q[0].lat_exp && q[0].has_lit)
                chk("literal result", result, q[0].lit);
            if (q.size() != 0 && (flush || (ov_exp && out_ready))) begin
                if (ov_exp) last_res = q[0].res;
                void'(q.pop_front());
            end else if (q.size() == 0 && in_valid && !flush) begin
                q.push_back('{res: model(op, a, b), lat_exp: model_lat(op, a, b),
                              has_lit: cur_has_lit, lit: cur_lit});
                lat = 0;
            end
        end
    end

    // Called at posedge+1 with the unit idle; presents the request for exactly one edge.
    task automatic start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic hl, input logic [31:0] lit);
        in_valid = 1'b1; op = o; a = x; b = y; cur_has_lit = hl; cur_lit = lit;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; cur_has_lit = 1'b0;
    endtask

    task automatic wait_idle(input logic rnd);
        int k;
        k = (rnd && $urandom_range(0, 15) == 0) ? int'($urandom_range(0, 40)) : -1;
        for (int i = 0; i < 400 && q.size() != 0; i++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            flush = (i == k);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        out_ready = 1'b1;
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle timeout: %0d operations outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        start(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB); wait_idle(1'b0);
        start(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000); wait_idle(1'b0);
        start(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE); wait_idle(1'b0);
        start(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF); wait_idle(1'b0);
        start(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD); wait_idle(1'b0);
        start(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF); wait_idle(1'b0);
        start(3'd5, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'h5555_5554); wait_idle(1'b0);
        start(3'd7, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'd2); wait_idle(1'b0);
        start(3'd4, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF); wait_idle(1'b0);
        start(3'd6, 32'd5, 32'd0, 1'b1, 32'd5); wait_idle(1'b0);
        start(3'd5, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF); wait_idle(1'b0);
        start(3'd7, 32'd5, 32'd0, 1'b1, 32'd5); wait_idle(1'b0);
        start(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000); wait_idle(1'b0);
        start(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0); wait_idle(1'b0);

        // Result held under backpressure while a second request is waiting.
        out_ready = 1'b0;
        start(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
        for (int i = 0; i < 60 && !(q.size() != 0 && lat >= q[0].lat_exp); i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle(1'b0);

        // Flush during the 10th CALC cycle.
        start(3'd4, $urandom & 32'h7FFF_FFFF, $urandom | 32'h1, 1'b0, 32'h0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start(3'd5, 32'd100, 32'd7, 1'b1, 32'd14); wait_idle(1'b0);

        // Asynchronous reset mid-operation.
        start(3'd3, $urandom, $urandom, 1'b0, 32'h0);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        start(3'd7, 32'd100, 32'd7, 1'b1, 32'd2); wait_idle(1'b0);

        for (int n = 0; n < 300; n++) begin
            start(3'($urandom), pick(), pick(), 1'b0, 32'h0);
            wait_idle(1'b1);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
